ddr_read_responder: RTL and testbench

Serving end of the single-beat DDR read interface driven by compute FUs such as the ternary matmul unit. It accepts one read request per cycle (address plus enable, no ready), queues it, issues it to the DRAM-side request/response port with a valid/ready handshake, and returns the read data to the FU in request order with a one-cycle valid pulse. Sticky error flags report request overflow and unsolicited responses instead of stalling, because the FU side has no back-pressure.

---
 rtl/config_pkg.sv | 10 +
 rtl/ddr_req_fifo.sv | 55 +++++
 rtl/ddr_read_responder.sv | 96 +++++++++
 tb/tb_ddr_read_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared DDR read interface types and default sizing
package config_pkg;

  typedef logic [31:0] ddr_address_t;
  typedef logic [31:0] ddr_data_t;

  localparam int DDR_REQ_DEPTH       = 8;
  localparam int DDR_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/ddr_req_fifo.sv
// rtl/ddr_req_fifo.sv - first-word fall-through request address FIFO
module ddr_req_fifo
  import config_pkg::*;
#(
  parameter int DEPTH = DDR_REQ_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  ddr_address_t data_i,
  output ddr_address_t data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  ddr_address_t mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    drop_o  = push_i && full_o && !do_pop;
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/ddr_read_responder.sv
// rtl/ddr_read_responder.sv - queues FU read requests, issues them to DRAM and returns data in order
module ddr_read_responder
  import config_pkg::*;
#(
  parameter int REQ_DEPTH       = DDR_REQ_DEPTH,
  parameter int MAX_OUTSTANDING = DDR_MAX_OUTSTANDING
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  ddr_address_t ddr_address_i,
  input  logic         ddr_r_en_i,
  output ddr_data_t    ddr_r_data_o,
  output logic         ddr_r_valid_o,
  output logic         mem_req_valid_o,
  input  logic         mem_req_ready_i,
  output ddr_address_t mem_req_addr_o,
  input  logic         mem_resp_valid_i,
  input  ddr_data_t    mem_resp_data_i,
  output logic         busy_o,
  output logic         overflow_o,
  output logic         resp_error_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_drop;
  logic          req_hs;
  logic          resp_ok;
  logic [CW-1:0] outst_q, outst_d;
  ddr_data_t     data_q, data_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic          err_q, err_d;

  ddr_req_fifo #(
    .DEPTH (REQ_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ddr_r_en_i),
    .pop_i   (req_hs),
    .data_i  (ddr_address_i),
    .data_o  (mem_req_addr_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // Issue gate looks only at the registered count; a same-cycle response frees nothing.
  always_comb begin
    mem_req_valid_o = !fifo_empty && (outst_q < MAX_CNT);
    req_hs          = mem_req_valid_o && mem_req_ready_i;
    resp_ok         = mem_resp_valid_i && (outst_q != '0);

    outst_d = outst_q;
    if (req_hs && !resp_ok) begin
      outst_d = outst_q + CW'(1);
    end else if (!req_hs && resp_ok) begin
      outst_d = outst_q - CW'(1);
    end

    data_d     = resp_ok ? mem_resp_data_i : data_q;
    valid_d    = resp_ok;
    overflow_d = overflow_q | fifo_drop;
    err_d      = err_q | (mem_resp_valid_i && (outst_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      outst_q    <= outst_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign ddr_r_data_o  = data_q;
  assign ddr_r_valid_o = valid_q;
  assign overflow_o    = overflow_q;
  assign resp_error_o  = err_q;
  assign busy_o        = !fifo_empty || (outst_q != '0);

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ddr_read_responder.sv
// tb/tb_ddr_read_responder.sv - scoreboard bench for ddr_read_responder
module tb_ddr_read_responder;
  import config_pkg::*;

  logic         clk = 1'b0;
  logic         rst_i;
  ddr_address_t ddr_address_i;
  logic         ddr_r_en_i;
  ddr_data_t    ddr_r_data_o;
  logic         ddr_r_valid_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  ddr_address_t mem_req_addr_o;
  logic         mem_resp_valid_i;
  ddr_data_t    mem_resp_data_i;
  logic         busy_o;
  logic         overflow_o;
  logic         resp_error_o;

  always #5 clk = ~clk;

  ddr_read_responder #(
    .REQ_DEPTH       (8),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .ddr_address_i    (ddr_address_i),
    .ddr_r_en_i       (ddr_r_en_i),
    .ddr_r_data_o     (ddr_r_data_o),
    .ddr_r_valid_o    (ddr_r_valid_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .busy_o           (busy_o),
    .overflow_o       (overflow_o),
    .resp_error_o     (resp_error_o)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  ddr_data_t    exp_data[$];
  ddr_address_t exp_addr[$];
  int           pend_due[$];
  ddr_data_t    pend_data[$];
  int           lat = 3;
  int           stray_cnt = 0;
  int           stray_done = 0;
  int           n_ret = 0;
  int           peak = 0;
  int           ncnt = 0;
  int           base;

  // Memory content is address ^ 0xDEED; expected values below are hand-computed from it.
  ddr_data_t burst_exp [8] = '{32'hDEED, 32'hDEEC, 32'hDEEF, 32'hDEEE,
                               32'hDEE9, 32'hDEE8, 32'hDEEB, 32'hDEEA};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input ddr_address_t a, input ddr_data_t d);
    ddr_r_en_i    = 1'b1;
    ddr_address_i = a;
    exp_addr.push_back(a);
    exp_data.push_back(d);
    tick();
    ddr_r_en_i = 1'b0;
  endtask

  task automatic do_reset();
    ddr_r_en_i = 1'b0;
    rst_i      = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_data.delete();
    exp_addr.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rdata"},    ddr_r_data_o, 0);
    check({tag, "_rvalid"},   ddr_r_valid_o, 0);
    check({tag, "_reqvalid"}, mem_req_valid_o, 0);
    check({tag, "_busy"},     busy_o, 0);
    check({tag, "_overflow"}, overflow_o, 0);
    check({tag, "_resperr"},  resp_error_o, 0);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy_o && pend_due.size() == 0 && exp_data.size() == 0 && !ddr_r_valid_o)
        done = 1'b1;
      else
        tick();
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s_timeout: busy=%0d pending=%0d expected_left=%0d", name, busy_o,
               pend_due.size(), exp_data.size());
    end
  endtask

  // DRAM model: logs each handshake and answers in order after lat cycles.
  initial begin
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    forever begin
      @(negedge clk);
      ncnt++;
      if (rst_i) peak = 0;
      if (!rst_i && mem_req_valid_o && mem_req_ready_i) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL issue_unexpected: got addr %h expected none", mem_req_addr_o);
        end else begin
          check("issue_addr", mem_req_addr_o, exp_addr.pop_front());
        end
        pend_due.push_back(ncnt + lat);
        pend_data.push_back(mem_req_addr_o ^ 32'hDEED);
      end
      mem_resp_valid_i = 1'b0;
      if (stray_cnt != stray_done) begin
        stray_done++;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hBAD0;
      end else if (pend_due.size() > 0 && pend_due[0] <= ncnt) begin
        void'(pend_due.pop_front());
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = pend_data.pop_front();
      end
      if (peak < pend_due.size()) peak = pend_due.size();
    end
  end

  // Monitor: every returned beat must match the oldest expected datum.
  initial begin
    forever begin
      @(negedge clk);
      if (ddr_r_valid_o) begin
        n_ret++;
        if (exp_data.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL ret_unexpected: got data %h expected no pulse", ddr_r_data_o);
        end else begin
          check("ret_data", ddr_r_data_o, exp_data.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    rst_i           = 1'b0;
    ddr_r_en_i      = 1'b0;
    ddr_address_i   = '0;
    mem_req_ready_i = 1'b0;
    tick();

    // Single read with a 3-cycle DRAM latency.
    do_reset();
    check_zero_outputs("reset");
    mem_req_ready_i = 1'b1;
    lat = 3;
    send(32'h40, 32'hDEAD);
    check("single_reqvalid", mem_req_valid_o, 1);
    check("single_reqaddr", mem_req_addr_o, 32'h40);
    check("single_busy", busy_o, 1);
    tick();
    check("single_reqvalid_after_hs", mem_req_valid_o, 0);
    tick();
    tick();
    check("single_rvalid_early", ddr_r_valid_o, 0);
    tick();
    check("single_rvalid", ddr_r_valid_o, 1);
    check("single_busy_done", busy_o, 0);
    tick();
    check("single_rvalid_pulse", ddr_r_valid_o, 0);
    wait_idle("single");

    // Burst of 8 with ready held low, then released.
    do_reset();
    mem_req_ready_i = 1'b0;
    lat = 6;
    for (int i = 0; i < 8; i++) send(ddr_address_t'(i), burst_exp[i]);
    check("burst_overflow", overflow_o, 0);
    check("burst_reqvalid", mem_req_valid_o, 1);
    base = n_ret;
    mem_req_ready_i = 1'b1;
    wait_idle("burst");
    check("burst_peak_outstanding", peak, 4);
    check("burst_returns", n_ret - base, 8);
    check("burst_resperr", resp_error_o, 0);

    // Push while full with a same-cycle pop.
    do_reset();
    mem_req_ready_i = 1'b0;
    lat = 3;
    base = n_ret;
    for (int i = 0; i < 8; i++) send(ddr_address_t'(i), burst_exp[i]);
    mem_req_ready_i = 1'b1;
    send(32'h8, 32'hDEE5);
    check("fullpop_overflow", overflow_o, 0);
    wait_idle("fullpop");
    check("fullpop_returns", n_ret - base, 9);
    check("fullpop_overflow_end", overflow_o, 0);

    // Overflow: the ninth request is dropped.
    do_reset();
    mem_req_ready_i = 1'b0;
    base = n_ret;
    for (int i = 0; i < 8; i++) send(ddr_address_t'(i), burst_exp[i]);
    ddr_r_en_i    = 1'b1;
    ddr_address_i = 32'h9;
    tick();
    ddr_r_en_i = 1'b0;
    check("ovf_set", overflow_o, 1);
    tick();
    tick();
    check("ovf_sticky", overflow_o, 1);
    mem_req_ready_i = 1'b1;
    wait_idle("ovf");
    check("ovf_returns", n_ret - base, 8);
    check("ovf_sticky_end", overflow_o, 1);

    // Unsolicited response with nothing outstanding.
    do_reset();
    check("stray_err_clear", resp_error_o, 0);
    base = n_ret;
    stray_cnt++;
    tick();
    tick();
    check("stray_err", resp_error_o, 1);
    check("stray_busy", busy_o, 0);
    tick();
    check("stray_no_pulse", n_ret - base, 0);
    send(32'h41, 32'hDEAC);
    wait_idle("stray_followup");
    check("stray_followup_returns", n_ret - base, 1);
    check("stray_err_sticky", resp_error_o, 1);

    // Reset with 2 outstanding and 3 queued.
    do_reset();
    lat = 20;
    mem_req_ready_i = 1'b1;
    send(32'h10, 32'hDEFD);
    send(32'h11, 32'hDEFC);
    send(32'h12, 32'hDEFF);
    mem_req_ready_i = 1'b0;
    send(32'h13, 32'hDEFE);
    send(32'h14, 32'hDEF9);
    check("midrst_outstanding", pend_due.size(), 2);
    check("midrst_busy", busy_o, 1);
    do_reset();
    check_zero_outputs("midrst");
    base = n_ret;
    for (int i = 0; i < 40 && pend_due.size() != 0; i++) tick();
    check("midrst_pending_drained", pend_due.size(), 0);
    tick();
    tick();
    check("midrst_stray_err", resp_error_o, 1);
    check("midrst_no_pulse", n_ret - base, 0);
    check("midrst_busy_end", busy_o, 0);
    check("final_scoreboard_empty", exp_data.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
